// File: rtl/a2d_pkg.sv
// Shared types and constants for the ADC128S interface.
// Channel map, SPI divider preset and state encodings.
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        READ
    } a2d_state_t;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SHIFT,
        BACK_PORCH
    } spi_state_t;

    localparam logic [2:0] CH_LFT  = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_BATT = 3'd5;

    // Preset puts the first SCLK fall 9 clocks after the start edge.
    localparam logic [4:0] SCLK_INIT = 5'b10111;

    // Divider values that mark sample, shift and end-of-frame edges.
    localparam logic [4:0] DIV_SMPL = 5'b01111;
    localparam logic [4:0] DIV_SHFT = 5'b11111;
    localparam logic [4:0] DIV_END  = 5'b11110;

    localparam logic [3:0] LAST_SMPL = 4'd15;

    // Round-robin order of the three live channels.
    function automatic logic [2:0] next_ch(input logic [2:0] ch);
        logic [2:0] nc;
        unique case (ch)
            CH_LFT:  nc = CH_RGHT;
            CH_RGHT: nc = CH_BATT;
            default: nc = CH_LFT;
        endcase
        return nc;
    endfunction

    // Channel select sits in bits [13:11] of the control word.
    function automatic logic [15:0] cmd_word(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_intf_spi_mstr16.sv
// Generic 16-bit SPI master, mode 3, SCLK = clk/32.
// Samples MISO at SCLK rise, shifts at SCLK fall.
module spi_mstr16
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rx
);

    spi_state_t  state;
    spi_state_t  state_nxt;
    logic [4:0]  sclk_div;
    logic [15:0] shft_reg;
    logic [3:0]  smpl_cnt;
    logic        miso_cap;
    logic        pending;
    logic        ss_q;
    logic        start;
    logic        finish;
    logic        smpl;
    logic        shft;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SPI_IDLE;
        else     state <= state_nxt;
    end

    // next state and per-edge strobes
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        smpl      = 1'b0;
        shft      = 1'b0;
        unique case (state)
            SPI_IDLE: begin
                if (wrt) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                smpl = (sclk_div == DIV_SMPL);
                // No shift on the first fall: nothing sampled yet.
                shft = (sclk_div == DIV_SHFT) && pending;
                if (smpl && (smpl_cnt == LAST_SMPL))
                    state_nxt = BACK_PORCH;
            end
            BACK_PORCH: begin
                // End one edge early so SCLK never makes a 17th fall.
                if (sclk_div == DIV_END) begin
                    finish    = 1'b1;
                    shft      = 1'b1;
                    state_nxt = SPI_IDLE;
                end
            end
            default: state_nxt = SPI_IDLE;
        endcase
    end

    // SCLK divider: parked at the preset whenever no frame is running
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sclk_div <= SCLK_INIT;
        else if (start || finish || (state == SPI_IDLE))
            sclk_div <= SCLK_INIT;
        else
            sclk_div <= sclk_div + 5'd1;
    end

    // MISO capture and sample bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_cap <= 1'b0;
            pending  <= 1'b0;
            smpl_cnt <= '0;
        end else if (start) begin
            pending  <= 1'b0;
            smpl_cnt <= '0;
        end else if (smpl) begin
            miso_cap <= MISO;
            pending  <= 1'b1;
            smpl_cnt <= smpl_cnt + 4'd1;
        end else if (shft) begin
            pending  <= 1'b0;
        end
    end

    // shift register: loads the command, returns the received word
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shft_reg <= '0;
        else if (start)
            shft_reg <= cmd;
        else if (shft)
            shft_reg <= {shft_reg[14:0], miso_cap};
    end

    // slave select and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q <= 1'b1;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (start)       ss_q <= 1'b0;
            else if (finish) ss_q <= 1'b1;
        end
    end

    assign SS_n = ss_q;
    assign SCLK = sclk_div[4] | ss_q;
    assign MOSI = shft_reg[15];
    assign rx   = shft_reg;

endmodule

// File: rtl/a2d_intf.sv
// ADC128S front end: round-robins channels 0, 4, 5.
// Two SPI frames per conversion; result kept per channel.
module a2d_intf
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        busy
);

    a2d_state_t  state;
    a2d_state_t  state_nxt;
    logic [2:0]  ch;
    logic        wrt;
    logic        latch;
    logic        done;
    logic [15:0] rx;
    logic        unused_hi;

    // Upper nibble of the read frame carries no data.
    assign unused_hi = ^rx[15:12];

    spi_mstr16 u_spi (
        .clk  (clk),
        .rst  (rst),
        .wrt  (wrt),
        .cmd  (cmd_word(ch)),
        .MISO (MISO),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .done (done),
        .rx   (rx)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // conversion sequencing: select frame, then read frame
    always_comb begin
        state_nxt = state;
        wrt       = 1'b0;
        latch     = 1'b0;
        unique case (state)
            IDLE: begin
                if (nxt) begin
                    wrt       = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (done) begin
                    wrt       = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                if (done) begin
                    latch     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            cnv_cmplt <= 1'b0;
        end else begin
            busy      <= (state_nxt != IDLE);
            cnv_cmplt <= latch;
        end
    end

    // result registers and channel pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch      <= CH_LFT;
            lft_ld  <= '0;
            rght_ld <= '0;
            batt    <= '0;
        end else if (latch) begin
            ch <= next_ch(ch);
            unique case (ch)
                CH_LFT:  lft_ld  <= rx[11:0];
                CH_RGHT: rght_ld <= rx[11:0];
                default: batt    <= rx[11:0];
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a behavioural ADC128S.
// Checks frame timing, command words and result routing.
module tb_a2d_intf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic        MISO = 1'b0;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;
    logic        cnv_cmplt;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int cmplt_cnt = 0;
    int e, e2, t, c0;

    logic [11:0] lft_val  = 12'h000;
    logic [11:0] rght_val = 12'h000;
    logic [11:0] batt_val = 12'h000;
    logic [15:0] exp_words [4];

    typedef struct {
        logic [15:0] word;
        int nfall;
        int nrise;
        int t_ss_fall;
        int t_fall1;
        int t_rise1;
        int t_rise2;
        int t_ss_rise;
    } xact_t;

    xact_t       q[$];
    xact_t       cur;
    logic [15:0] tx = 16'h0000;
    logic [2:0]  last_ch = 3'd0;

    a2d_intf dut (
        .clk       (clk),
        .rst       (rst),
        .nxt       (nxt),
        .MISO      (MISO),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // edge counter; cnv_cmplt here is the pre-edge value
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cnv_cmplt === 1'b1) cmplt_cnt = cmplt_cnt + 1;
    end

    function automatic logic [11:0] adc_val(input logic [2:0] ch);
        case (ch)
            3'd0:    return lft_val;
            3'd4:    return rght_val;
            3'd5:    return batt_val;
            default: return 12'hFFF;
        endcase
    endfunction

    // ADC: returns data for the channel named in the previous frame
    always @(negedge SS_n) begin
        cur.word      = 16'h0000;
        cur.nfall     = 0;
        cur.nrise     = 0;
        cur.t_ss_fall = cyc;
        cur.t_fall1   = -1;
        cur.t_rise1   = -1;
        cur.t_rise2   = -1;
        cur.t_ss_rise = -1;
        tx = {4'hF, adc_val(last_ch)};
    end

    always @(negedge SCLK) begin
        if (SS_n === 1'b0) begin
            if (cur.nfall == 0) cur.t_fall1 = cyc;
            MISO = (cur.nfall < 16) ? tx[15 - cur.nfall] : 1'b0;
            cur.nfall++;
        end
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0 && rst === 1'b0) begin
            if (cur.nrise == 0)      cur.t_rise1 = cyc;
            else if (cur.nrise == 1) cur.t_rise2 = cyc;
            cur.word = {cur.word[14:0], MOSI};
            cur.nrise++;
        end
    end

    always @(posedge SS_n) begin
        cur.t_ss_rise = cyc;
        if (cur.nrise == 16) last_ch = cur.word[13:11];
        q.push_back(cur);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // call at a negedge; ep is the edge that samples nxt
    task automatic pulse_nxt(output int ep);
        ep = cyc + 1;
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    // returns at the negedge where cnv_cmplt is high
    task automatic wait_cmplt(output int tc);
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (cnv_cmplt === 1'b1) break;
        end
        chk("cmplt_seen", {31'd0, cnv_cmplt}, 32'd1);
        tc = cyc;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        exp_words = '{16'h0000, 16'h2000, 16'h2800, 16'h0000};

        // power-on reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ss_n", {31'd0, SS_n}, 32'd1);
        chk("rst_sclk", {31'd0, SCLK}, 32'd1);
        chk("rst_mosi", {31'd0, MOSI}, 32'd0);
        chk("rst_lft", {20'd0, lft_ld}, 32'd0);
        chk("rst_rght", {20'd0, rght_ld}, 32'd0);
        chk("rst_batt", {20'd0, batt}, 32'd0);
        chk("rst_cmplt", {31'd0, cnv_cmplt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // single conversion on channel 0 with full timing checks
        lft_val = 12'hABC;
        q.delete();
        pulse_nxt(e);
        chk("busy_set", {31'd0, busy}, 32'd1);
        chk("ss_low", {31'd0, SS_n}, 32'd0);
        wait_cmplt(t);
        chk("cmplt_lat", t, e + 1042);
        chk("lft_abc", {20'd0, lft_ld}, 32'hABC);
        chk("busy_clr", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("cmplt_1cyc", {31'd0, cnv_cmplt}, 32'd0);
        chk("a_nframes", q.size(), 2);
        if (q.size() == 2) begin
            chk("a_w0", {16'd0, q[0].word}, 32'h0000);
            chk("a_w1", {16'd0, q[1].word}, 32'h0000);
            chk("a_ssfall", q[0].t_ss_fall, e);
            chk("a_fall1", q[0].t_fall1, e + 9);
            chk("a_rise1", q[0].t_rise1, e + 25);
            chk("a_rise2", q[0].t_rise2, e + 57);
            chk("a_nfall", q[0].nfall, 16);
            chk("a_nrise", q[0].nrise, 16);
            chk("a_ssrise", q[0].t_ss_rise, e + 520);
            chk("a_ss2fall", q[1].t_ss_fall, e + 521);
            chk("a_ss2rise", q[1].t_ss_rise, e + 1041);
            chk("a_nfall2", q[1].nfall, 16);
        end

        // mid-simulation reset clears results and pointer
        rst = 1'b1;
        #1;
        chk("rst2_lft", {20'd0, lft_ld}, 32'd0);
        chk("rst2_ss_n", {31'd0, SS_n}, 32'd1);
        chk("rst2_sclk", {31'd0, SCLK}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // round robin, each nxt issued the cycle cnv_cmplt is high
        lft_val  = 12'h123;
        rght_val = 12'h456;
        batt_val = 12'h789;
        q.delete();
        pulse_nxt(e);
        for (int k = 0; k < 4; k++) begin
            wait_cmplt(t);
            chk("rr_lat", t, e + 1042);
            chk("rr_nframes", q.size(), 2);
            if (q.size() == 2) begin
                chk("rr_w0", {16'd0, q[0].word}, {16'd0, exp_words[k]});
                chk("rr_w1", {16'd0, q[1].word}, {16'd0, exp_words[k]});
            end
            case (k)
                0: chk("rr_lft", {20'd0, lft_ld}, 32'h123);
                1: chk("rr_rght", {20'd0, rght_ld}, 32'h456);
                2: chk("rr_batt", {20'd0, batt}, 32'h789);
                default: chk("rr_lft2", {20'd0, lft_ld}, 32'h321);
            endcase
            if (k == 2) lft_val = 12'h321;
            if (k < 3) begin
                q.delete();
                pulse_nxt(e2);
                chk("rr_b2b", e2, t + 1);
                e = e2;
            end
        end

        // nxt while busy and at the completion edge is ignored
        @(negedge clk);
        rght_val = 12'h9A9;
        q.delete();
        c0 = cmplt_cnt;
        pulse_nxt(e);
        wait_until(e + 99);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        wait_until(e + 1041);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        chk("ign_cmplt", {31'd0, cnv_cmplt}, 32'd1);
        chk("ign_rght", {20'd0, rght_ld}, 32'h9A9);
        repeat (60) @(negedge clk);
        chk("ign_count", cmplt_cnt, c0 + 1);
        chk("ign_busy", {31'd0, busy}, 32'd0);
        chk("ign_nframes", q.size(), 2);

        // reset partway through a channel-5 frame
        q.delete();
        c0 = cmplt_cnt;
        pulse_nxt(e);
        wait_until(e + 300);
        rst = 1'b1;
        #1;
        chk("ab_ss_n", {31'd0, SS_n}, 32'd1);
        chk("ab_sclk", {31'd0, SCLK}, 32'd1);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_rght", {20'd0, rght_ld}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("ab_nframes", q.size(), 1);
        if (q.size() == 1) begin
            chk("ab_nrise", q[0].nrise, 9);
            chk("ab_partial", {16'd0, q[0].word}, 32'h0050);
        end
        repeat (1100) @(negedge clk);
        chk("ab_nocmplt", cmplt_cnt, c0);

        // after release, conversion restarts on channel 0
        lft_val = 12'h5A5;
        q.delete();
        pulse_nxt(e);
        wait_cmplt(t);
        chk("ab_lat", t, e + 1042);
        chk("ab_lft", {20'd0, lft_ld}, 32'h5A5);
        chk("ab_batt", {20'd0, batt}, 32'd0);
        if (q.size() == 2)
            chk("ab_w0", {16'd0, q[0].word}, 32'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
